edge_result_collector: RTL and testbench
========================================

# edge_result_collector

Receiving end of the edge detector's output stream. Samples the 16-bit sign-extended Sobel words presented on `writeMem` while `finalConvDone` is high: 676 horizontal-gradient (Gx) words, then 676 vertical-gradient (Gy) words. Computes a saturated 8-bit magnitude |Gx|+|Gy| and a threshold edge bit per pixel, buffers the 26x26 result, and drains it downstream over a valid/ready pixel stream in raster order.

## Interface
- `IMG_W`, default 26: result row width in pixels.
- `IMG_H`, default 26: result row count. Frame size `N = IMG_W*IMG_H`.
- `MAG_W`, default 8: magnitude output width.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `finalConvDone`  in  1  word-valid from the detector; one word per cycle while high.
- `writeMem`  in  16  signed gradient word (13-bit value, sign-extended).
- `threshold`  in  MAG_W  edge threshold; sampled on the first Gx word of each frame.
- `pix_ready`  in  1  downstream accept.
- `pix_valid`  out  1  output pixel valid.
- `pix_data`  out  MAG_W  saturated magnitude.
- `pix_edge`  out  1  `pix_data >= threshold` (latched value).
- `pix_eol`  out  1  last pixel of a row (column IMG_W-1).
- `pix_last`  out  1  last pixel of the frame (index N-1).
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse after the last pixel handshake.
- `overrun`  out  1  sticky; words arrived while not accepting. Cleared only by reset.

## Operation
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE, CAP_X, CAP_Y, DRAIN.
- IDLE: first cycle with `finalConvDone=1` is Gx word 0. Store it, latch `threshold`, set `in_idx=1`, go to CAP_X.
- CAP_X: each cycle with `finalConvDone=1`, store the word at `gx_buf[in_idx]` and increment. After word N-1, clear `in_idx` and go to CAP_Y. Cycles with `finalConvDone=0` are stalls: no capture, no state change.
- CAP_Y: each valid word is index `in_idx`.
  - Stage 1: register Gy and issue a `gx_buf[in_idx]` read.
  - Stage 2: |Gx|+|Gy| is computed 18 bits wide (|-32768| = 32768 representable), saturated to 2^MAG_W-1, and written to `mag_buf[idx]`.
  - After the stage-2 write of index N-1, go to DRAIN.
- DRAIN: reads `mag_buf` in order `0..N-1` and presents each pixel on the output with `pix_edge`, `pix_eol` and `pix_last`. A handshake is `pix_valid & pix_ready`. After the `pix_last` handshake, pulse `frame_done` and go to IDLE.
- Input words with `finalConvDone=1` in DRAIN are dropped and set `overrun`.
- Words after the 2N-th of a frame are handled by the IDLE rule only once `finalConvDone` has been low for at least one cycle. Until then they are ignored and set `overrun`.
- Reset in any state aborts the frame: return to IDLE with reset values. Buffer contents are don't-care.

## Timing
- Input throughput 1 word/cycle; no backpressure toward the detector.
- Magnitude pipeline latency: 2 cycles from the Gy word to the `mag_buf` write.
- DRAIN entered the cycle after the final write. First `pix_valid` occurs 2 cycles later (1-cycle synchronous RAM read plus output register).
- Drain throughput 1 pixel/cycle while `pix_ready` is held high. A prefetch register removes bubbles.
- While `pix_valid=1` and `pix_ready=0`, `pix_data`, `pix_edge`, `pix_eol` and `pix_last` hold stable.
- `pix_valid` never drops before a handshake.
- `frame_done` is asserted the cycle after the final handshake, concurrently with `busy=0`.
- `threshold` changes mid-frame have no effect.

## Structure
- Package `edge_pkg`:
  - `IMG_W`/`IMG_H` defaults, N, detector word width 16.
  - State enum `collector_state_t`.
  - Saturation function `sat_mag`.
- Sub-module `edge_buf_ram`: 1-write/1-read synchronous RAM, parameterised depth and width. Instantiated twice:
  - `gx_buf`: N x 16.
  - `mag_buf`: N x MAG_W.

## Test plan
- Gx all +3, Gy all -4, threshold 5, `pix_ready`=1 → 676 pixels, `pix_data`=7, `pix_edge`=1.
  - `pix_eol` on every 26th pixel; `pix_last` on the 676th.
  - `frame_done` pulse after the last pixel.
- Gx=4095, Gy=-4096 at index 0; Gx=-32768, Gy=0 at index 1; Gx=Gy=0 elsewhere; threshold 1 → pixels 0 and 1 = 255, edge 1; all others 0, edge 0.
- Ramp Gx[k]=k, Gy=0, threshold 100; `pix_ready` high 1 cycle in 3 → values 0..255 then saturated 255. No duplicates or skips; outputs stable while stalled.
- `finalConvDone` low for 10 cycles after Gy word 300 → stall only; output identical to the unstalled run.
- `finalConvDone` held high for 5 extra cycles after word 1351 → `overrun`=1; drain still yields exactly 676 correct pixels.
- Reset asserted at Gy word 200, then a full clean frame → outputs at reset values during reset; second frame output exactly correct; `overrun`=0.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared constants, state type and magnitude helpers for the edge result collector.
package edge_pkg;

  localparam int unsigned DefImgW = 26;
  localparam int unsigned DefImgH = 26;
  localparam int unsigned DefN    = DefImgW * DefImgH;
  localparam int unsigned WordW   = 16;
  localparam int unsigned SumW    = 18;

  typedef enum logic [1:0] {
    StIdle,
    StCapX,
    StCapY,
    StDrain
  } collector_state_t;

  // |w| of a two's-complement detector word; 18 bits so that |-32768| is representable.
  function automatic logic [SumW-1:0] abs_word(input logic [WordW-1:0] w);
    logic [SumW-1:0] ext;
    ext = {{(SumW - WordW){w[WordW-1]}}, w};
    return w[WordW-1] ? (~ext + 1'b1) : ext;
  endfunction

  function automatic logic [SumW-1:0] sat_mag(input logic [SumW-1:0] sum,
                                              input int unsigned   mag_w);
    logic [SumW-1:0] max_val;
    max_val = SumW'((1 << mag_w) - 1);
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/edge_buf_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous (1-cycle) read port.
module edge_buf_ram #(
  parameter int unsigned Depth = 676,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/edge_result_collector.sv
// Collects a Gx frame then a Gy frame, computes saturated |Gx|+|Gy| per pixel and
// drains the result as a raster-order valid/ready pixel stream.
module edge_result_collector
  import edge_pkg::*;
#(
  parameter int unsigned IMG_W = DefImgW,
  parameter int unsigned IMG_H = DefImgH,
  parameter int unsigned MAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             finalConvDone,
  input  logic [15:0]      writeMem,
  input  logic [MAG_W-1:0] threshold,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [MAG_W-1:0] pix_data,
  output logic             pix_edge,
  output logic             pix_eol,
  output logic             pix_last,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int unsigned N     = IMG_W * IMG_H;
  localparam int unsigned AddrW = $clog2(N);
  localparam int unsigned CntW  = $clog2(N + 1);
  localparam int unsigned ColW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [AddrW-1:0] LastAddr = AddrW'(N - 1);
  localparam logic [CntW-1:0]  NCnt     = CntW'(N);
  localparam logic [ColW-1:0]  LastCol  = ColW'(IMG_W - 1);

  collector_state_t state_q, state_d;

  logic [AddrW-1:0] in_idx_q, in_idx_d;
  logic [MAG_W-1:0] thr_q, thr_d;
  logic             overrun_q, overrun_d;
  logic             wait_low_q, wait_low_d;
  logic             y_done_q, y_done_d;
  logic             s1_vld_q, s1_vld_d;
  logic [AddrW-1:0] s1_idx_q, s1_idx_d;
  logic [WordW-1:0] gy_q, gy_d;
  logic [CntW-1:0]  rd_idx_q, rd_idx_d;
  logic             rd_pend_q, rd_pend_d;
  logic             pf_vld_q, pf_vld_d;
  logic [MAG_W-1:0] pf_data_q, pf_data_d;
  logic             out_vld_q, out_vld_d;
  logic [MAG_W-1:0] out_data_q, out_data_d;
  logic [AddrW-1:0] out_cnt_q, out_cnt_d;
  logic [ColW-1:0]  col_q, col_d;
  logic             frame_done_q, frame_done_d;

  logic             gx_we;
  logic [WordW-1:0] gx_rdata;
  logic [MAG_W-1:0] mag_wdata, mag_rdata;
  logic [SumW-1:0]  sum;
  logic             pop, rd_issue;
  logic [1:0]       occ;

  edge_buf_ram #(
    .Depth(N),
    .Width(WordW),
    .AddrW(AddrW)
  ) gx_buf (
    .clk_i  (clk),
    .we_i   (gx_we),
    .waddr_i(in_idx_q),
    .wdata_i(writeMem),
    .raddr_i(in_idx_q),
    .rdata_o(gx_rdata)
  );

  assign sum       = abs_word(gx_rdata) + abs_word(gy_q);
  assign mag_wdata = MAG_W'(sat_mag(sum, MAG_W));

  edge_buf_ram #(
    .Depth(N),
    .Width(MAG_W),
    .AddrW(AddrW)
  ) mag_buf (
    .clk_i  (clk),
    .we_i   (s1_vld_q),
    .waddr_i(s1_idx_q),
    .wdata_i(mag_wdata),
    .raddr_i(AddrW'(rd_idx_q)),
    .rdata_o(mag_rdata)
  );

  assign pop = out_vld_q & pix_ready;
  assign occ = 2'(out_vld_q) + 2'(pf_vld_q) + 2'(rd_pend_q);

  always_comb begin
    state_d      = state_q;
    in_idx_d     = in_idx_q;
    thr_d        = thr_q;
    overrun_d    = overrun_q;
    wait_low_d   = wait_low_q;
    y_done_d     = y_done_q;
    s1_vld_d     = 1'b0;
    s1_idx_d     = s1_idx_q;
    gy_d         = gy_q;
    rd_idx_d     = rd_idx_q;
    rd_pend_d    = 1'b0;
    pf_vld_d     = pf_vld_q;
    pf_data_d    = pf_data_q;
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_cnt_d    = out_cnt_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    gx_we        = 1'b0;
    rd_issue     = 1'b0;

    // The burst that completed the previous frame must end before a new frame can start.
    if (!finalConvDone) begin
      wait_low_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (finalConvDone) begin
          if (wait_low_q) begin
            overrun_d = 1'b1;
          end else begin
            gx_we    = 1'b1;
            thr_d    = threshold;
            in_idx_d = AddrW'(1);
            state_d  = StCapX;
          end
        end
      end

      StCapX: begin
        if (finalConvDone) begin
          gx_we = 1'b1;
          if (in_idx_q == LastAddr) begin
            in_idx_d = '0;
            state_d  = StCapY;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end

      StCapY: begin
        if (finalConvDone) begin
          if (y_done_q) begin
            overrun_d = 1'b1;
          end else begin
            s1_vld_d = 1'b1;
            s1_idx_d = in_idx_q;
            gy_d     = writeMem;
            if (in_idx_q == LastAddr) begin
              in_idx_d   = '0;
              y_done_d   = 1'b1;
              wait_low_d = 1'b1;
            end else begin
              in_idx_d = in_idx_q + 1'b1;
            end
          end
        end
        if (s1_vld_q && (s1_idx_q == LastAddr)) begin
          state_d   = StDrain;
          y_done_d  = 1'b0;
          rd_idx_d  = '0;
          out_cnt_d = '0;
          col_d     = '0;
        end
      end

      StDrain: begin
        if (finalConvDone) begin
          overrun_d = 1'b1;
        end
        // Issue a read only if out + prefetch can absorb everything in flight.
        rd_issue  = (rd_idx_q != NCnt) && ((occ - 2'(pop)) < 2'd2);
        rd_pend_d = rd_issue;
        if (rd_issue) begin
          rd_idx_d = rd_idx_q + 1'b1;
        end

        if (!out_vld_q || pop) begin
          if (pf_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = pf_data_q;
            pf_vld_d   = rd_pend_q;
            pf_data_d  = mag_rdata;
          end else if (rd_pend_q) begin
            out_vld_d  = 1'b1;
            out_data_d = mag_rdata;
          end else begin
            out_vld_d = 1'b0;
          end
        end else if (rd_pend_q) begin
          pf_vld_d  = 1'b1;
          pf_data_d = mag_rdata;
        end

        if (pop) begin
          if (out_cnt_q == LastAddr) begin
            out_cnt_d    = '0;
            col_d        = '0;
            rd_idx_d     = '0;
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
            col_d     = (col_q == LastCol) ? '0 : col_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      in_idx_q     <= '0;
      thr_q        <= '0;
      overrun_q    <= 1'b0;
      wait_low_q   <= 1'b0;
      y_done_q     <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_idx_q     <= '0;
      gy_q         <= '0;
      rd_idx_q     <= '0;
      rd_pend_q    <= 1'b0;
      pf_vld_q     <= 1'b0;
      pf_data_q    <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_cnt_q    <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_idx_q     <= in_idx_d;
      thr_q        <= thr_d;
      overrun_q    <= overrun_d;
      wait_low_q   <= wait_low_d;
      y_done_q     <= y_done_d;
      s1_vld_q     <= s1_vld_d;
      s1_idx_q     <= s1_idx_d;
      gy_q         <= gy_d;
      rd_idx_q     <= rd_idx_d;
      rd_pend_q    <= rd_pend_d;
      pf_vld_q     <= pf_vld_d;
      pf_data_q    <= pf_data_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_cnt_q    <= out_cnt_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_valid  = out_vld_q;
  assign pix_data   = out_data_q;
  assign pix_edge   = out_vld_q && (out_data_q >= thr_q);
  assign pix_eol    = out_vld_q && (col_q == LastCol);
  assign pix_last   = out_vld_q && (out_cnt_q == LastAddr);
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_edge_result_collector.sv
// Randomized bench for edge_result_collector against a per-pixel arithmetic reference model.
module tb_edge_result_collector;

  localparam int IMG_W = 26;
  localparam int IMG_H = 26;
  localparam int N     = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fcd = 1'b0;
  logic [15:0] wm = '0;
  logic [7:0] thr_in = '0;
  logic       pix_ready = 1'b0;
  logic       pix_valid, pix_edge, pix_eol, pix_last, busy, frame_done, overrun;
  logic [7:0] pix_data;

  edge_result_collector #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .MAG_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .finalConvDone(fcd),
    .writeMem     (wm),
    .threshold    (thr_in),
    .pix_ready    (pix_ready),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_edge     (pix_edge),
    .pix_eol      (pix_eol),
    .pix_last     (pix_last),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int gx [N];
  int gy [N];
  int thr = 0;
  int ready_mode = 0;
  int cyc = 0;
  int pix_idx = 0;
  int done_cnt = 0;
  int last_hs_cyc = -10;
  int exp_ovr = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit prev_wait = 1'b0;
  bit prev_fd = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int exp_mag(input int k);
    int s;
    s = iabs(gx[k]) + iabs(gy[k]);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0)      pix_ready = 1'b1;
    else if (ready_mode == 1) pix_ready = (cyc % 3 == 0);
    else                      pix_ready = 1'($urandom_range(0, 1));
  end

  // Every valid cycle is checked against the model pixel at the current stream position.
  always @(negedge clk) begin
    if (reset) begin
      pix_idx   = 0;
      prev_wait = 1'b0;
      prev_fd   = 1'b0;
    end else begin
      if (prev_wait) check("valid_hold", 32'(pix_valid), 1);
      if (prev_fd) check("fd_pulse", 32'(frame_done), 0);
      if (pix_valid) begin
        if (pix_idx < N) begin
          check("pix_data", 32'(pix_data), exp_mag(pix_idx));
          check("pix_edge", 32'(pix_edge), 32'(exp_mag(pix_idx) >= thr));
          check("pix_eol", 32'(pix_eol), 32'(pix_idx % IMG_W == IMG_W - 1));
          check("pix_last", 32'(pix_last), 32'(pix_idx == N - 1));
        end else begin
          check("extra_pix", pix_idx, N - 1);
        end
        if (pix_ready) begin
          if (pix_last) last_hs_cyc = cyc;
          pix_idx++;
        end
      end
      if (frame_done) begin
        check("fd_busy", 32'(busy), 0);
        check("fd_gap", cyc - last_hs_cyc, 1);
        check("pix_count", pix_idx, N);
        pix_idx = 0;
        done_cnt++;
      end
      prev_wait = pix_valid && !pix_ready;
      prev_fd   = frame_done;
    end
  end

  // Sends n_words of the Gx-then-Gy stream; optional stall before Gy word stall_at
  // and extra words after the last one with finalConvDone still high.
  task automatic drive_frame(input int n_words, input int stall_at, input int stall_len,
                             input int extra);
    for (int i = 0; i < n_words; i++) begin
      if (i == N + stall_at) begin
        fcd = 1'b0;
        repeat (stall_len) tick();
      end
      fcd    = 1'b1;
      wm     = (i < N) ? 16'(gx[i]) : 16'(gy[i - N]);
      thr_in = (i == 0) ? 8'(thr) : 8'($urandom);
      tick();
    end
    for (int e = 0; e < extra; e++) begin
      fcd = 1'b1;
      wm  = 16'($urandom);
      tick();
    end
    fcd = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    int t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < 5000) begin
      tick();
      t++;
    end
    check("drain_done", done_cnt, start + 1);
    check("overrun", 32'(overrun), exp_ovr);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        gx[k] = int'($urandom_range(0, 8191)) - 4096;
        gy[k] = int'($urandom_range(0, 8191)) - 4096;
      end else begin
        gx[k] = int'($urandom_range(0, 300)) - 150;
        gy[k] = int'($urandom_range(0, 300)) - 150;
      end
    end
    thr = int'($urandom_range(0, 255));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 0);
    check({tag, "_data"}, 32'(pix_data), 0);
    check({tag, "_edge"}, 32'(pix_edge), 0);
    check({tag, "_eol"}, 32'(pix_eol), 0);
    check({tag, "_last"}, 32'(pix_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_fdone"}, 32'(frame_done), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    reset = 1'b0;
    tick();

    // Constant frame: |3|+|-4| = 7
    for (int k = 0; k < N; k++) begin
      gx[k] = 3;
      gy[k] = -4;
    end
    thr = 5;
    ready_mode = 0;
    drive_frame(2 * N, -1, 0, 0);
    wait_done();

    // Saturation corners
    for (int k = 0; k < N; k++) begin
      gx[k] = 0;
      gy[k] = 0;
    end
    gx[0] = 4095;
    gy[0] = -4096;
    gx[1] = -32768;
    thr = 1;
    drive_frame(2 * N, -1, 0, 0);
    wait_done();

    // Ramp with sparse ready
    for (int k = 0; k < N; k++) begin
      gx[k] = k;
      gy[k] = 0;
    end
    thr = 100;
    ready_mode = 1;
    drive_frame(2 * N, -1, 0, 0);
    wait_done();

    // Random frame, then the same frame with an input stall
    fill_random();
    ready_mode = 2;
    drive_frame(2 * N, -1, 0, 0);
    wait_done();
    drive_frame(2 * N, 301, 10, 0);
    wait_done();

    // Extra words after the frame set overrun but do not disturb the drain
    fill_random();
    ready_mode = 0;
    drive_frame(2 * N, -1, 0, 5);
    exp_ovr = 1;
    wait_done();

    // Reset mid-Gy, then a clean frame
    fill_random();
    drive_frame(N + 200, -1, 0, 0);
    fcd   = 1'b1;
    wm    = 16'(gy[200]);
    reset = 1'b1;
    tick();
    fcd = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outputs("mid_rst");
    tick();
    reset = 1'b0;
    exp_ovr = 0;
    tick();
    fill_random();
    ready_mode = 2;
    drive_frame(2 * N, -1, 0, 0);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
